mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_pick.sv | 20 ++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way priority pick: a lone requester always wins, a tie goes to ptr.
import mem_arb_pkg::*;

module mem_arb_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant_c
);

  // One-hot grant from the valids and the priority pointer
  always_comb begin
    grant_c = 2'b00;
    if (valid == 2'b11) begin
      grant_c = ptr ? 2'b10 : 2'b01;
    end else begin
      grant_c = valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory with optional lock.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking in
// IDLE; without it requester 0 always wins ties.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_we,
  input  logic        req0_lock,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_we,
  input  logic        req1_lock,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  // Count value at which the next locked beat is the last one allowed
  localparam logic [LOCK_CNT_W-1:0] LAST_CNT = LOCK_CNT_W'(MAX_LOCK - 1);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic [LOCK_CNT_W-1:0] lock_cnt_nxt;
  logic                  ptr;
  logic [1:0]            pick_gnt;
  logic [1:0]            gnt;
  logic                  sel_lock;
  logic [3:0]            sel_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_nxt;

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
    end
  end
`else
  assign ptr = 1'b0;
`endif

  mem_arb_pick u_pick (
    .valid   ({req1_valid, req0_valid}),
    .ptr     (ptr),
    .grant_c (pick_gnt)
  );

  // Grant: arbitrate in IDLE, only the owner while locked, nothing in reset
  always_comb begin
    gnt = 2'b00;
    case (state)
      IDLE:    gnt = pick_gnt;
      LOCK0:   gnt = {1'b0, req0_valid};
      LOCK1:   gnt = {req1_valid, 1'b0};
      default: gnt = 2'b00;
    endcase
    if (rst) begin
      gnt = 2'b00;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Memory port mux of the granted requester's fields
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    sel_we    = '0;
    sel_lock  = 1'b0;
    if (gnt[0]) begin
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
      sel_we    = req0_we;
      sel_lock  = req0_lock;
    end else if (gnt[1]) begin
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
      sel_we    = req1_we;
      sel_lock  = req1_lock;
    end
    mem_we = sel_we;
    mem_re = (|gnt) && (sel_we == 4'b0000);
  end

  // FSM state and lock beat counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Next state: lock entry on a locked IDLE beat, exit on unlock or beat limit
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_nxt      = ptr;
`endif
    case (state)
      IDLE: begin
        if (|gnt) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_nxt = gnt[0];
`endif
          if (sel_lock && (MAX_LOCK > 1)) begin
            state_nxt    = gnt[1] ? LOCK1 : LOCK0;
            lock_cnt_nxt = LOCK_CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (|gnt) begin
          if (!sel_lock) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
          end else if (lock_cnt >= LAST_CNT) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_nxt      = gnt[0];
`endif
          end else begin
            lock_cnt_nxt = lock_cnt + LOCK_CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // Read responses: one-cycle pulse with data captured from the memory
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= gnt[0] && mem_re;
      rsp1_valid <= gnt[1] && mem_re;
      if (gnt[0] && mem_re) begin
        rsp0_rdata <= mem_rdata;
      end
      if (gnt[1] && mem_re) begin
        rsp1_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random
// traffic, checked against a transaction-level model of ownership/priority.
// Honours MEM_ARB_ROUND_ROBIN_EN for the expected tie-break rule.
module tb_mem_port_arbiter;

  localparam int MAXL = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  r_valid;
  logic [1:0]  r_lock;
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_we [2];

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_re;
  logic [31:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  logic [31:0] mem_arr [256];
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  // Reference model state
  int          owner;
  int          beats;
  int          pref;
  logic [31:0] exp_rdata [2];
  logic [1:0]  exp_rspv;
  logic        obs_r0, obs_r1;
  int          checks, errors;

  mem_port_arbiter #(.MAX_LOCK(MAXL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (r_valid[0]),
    .req0_ready (req0_ready),
    .req0_addr  (r_addr[0]),
    .req0_wdata (r_wdata[0]),
    .req0_we    (r_we[0]),
    .req0_lock  (r_lock[0]),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (r_valid[1]),
    .req1_ready (req1_ready),
    .req1_addr  (r_addr[1]),
    .req1_wdata (r_wdata[1]),
    .req1_we    (r_we[1]),
    .req1_lock  (r_lock[1]),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Who should own the port this cycle (-1 = nobody)
  function automatic int model_grant();
    if (rst) return -1;
    if (owner >= 0) return r_valid[owner] ? owner : -1;
    if (r_valid == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return pref;
`else
      return 0;
`endif
    end
    if (r_valid[0]) return 0;
    if (r_valid[1]) return 1;
    return -1;
  endfunction

  task automatic set_req(input int n, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] we, input logic lk);
    r_valid[n] = v;
    r_addr[n]  = a;
    r_wdata[n] = wd;
    r_we[n]    = we;
    r_lock[n]  = lk;
  endtask

  task automatic idle_reqs();
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // One clock: check combinational side, advance model, check responses
  task automatic run_cycle();
    int          g;
    logic [31:0] e_addr, e_wdata, rd_word;
    logic [3:0]  e_we;
    logic        e_lock;
    #1;
    g = model_grant();
    e_addr  = (g >= 0) ? r_addr[g]  : 32'h0;
    e_wdata = (g >= 0) ? r_wdata[g] : 32'h0;
    e_we    = (g >= 0) ? r_we[g]    : 4'h0;
    e_lock  = (g >= 0) ? r_lock[g]  : 1'b0;
    obs_r0  = req0_ready;
    obs_r1  = req1_ready;
    check("ready0", 32'(req0_ready), 32'(g == 0));
    check("ready1", 32'(req1_ready), 32'(g == 1));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_re", 32'(mem_re), 32'((g >= 0) && (e_we == 4'h0)));
    rd_word = mem_arr[e_addr[9:2]];
    @(posedge clk);
    #1;
    exp_rspv = 2'b00;
    if (rst) begin
      owner = -1; beats = 0; pref = 0;
      exp_rdata[0] = 32'h0;
      exp_rdata[1] = 32'h0;
    end else if (g >= 0) begin
      if (e_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (e_we[b]) mem_arr[e_addr[9:2]][8*b +: 8] = e_wdata[8*b +: 8];
      end else begin
        exp_rspv[g]  = 1'b1;
        exp_rdata[g] = rd_word;
      end
      if (owner < 0) begin
        pref = 1 - g;
        if (e_lock && MAXL > 1) begin
          owner = g;
          beats = 1;
        end
      end else if (!e_lock) begin
        owner = -1;
        beats = 0;
      end else begin
        beats++;
        if (beats == MAXL) begin
          owner = -1;
          beats = 0;
          pref  = 1 - g;
        end
      end
    end
    check("rsp0_valid", 32'(rsp0_valid), 32'(exp_rspv[0]));
    check("rsp1_valid", 32'(rsp1_valid), 32'(exp_rspv[1]));
    check("rsp0_rdata", rsp0_rdata, exp_rdata[0]);
    check("rsp1_rdata", rsp1_rdata, exp_rdata[1]);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    owner = -1; beats = 0; pref = 0;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    exp_rspv = 2'b00;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[64] = 32'hDEADBEEF;
    rst = 1'b1;
    set_req(0, 1'b1, 32'h4, 32'h0, 4'h0, 1'b1);
    set_req(1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1);
    @(negedge clk);

    // Reset with both requesters valid: nothing granted, no responses
    run_cycle();
    run_cycle();
    rst = 1'b0;
    idle_reqs();
    run_cycle();

    // Byte write then read-back of the same word
    set_req(0, 1'b1, 32'h0, 32'h0000AB00, 4'b0010, 1'b0);
    run_cycle();
    set_req(0, 1'b1, 32'h0, 32'h0, 4'b0000, 1'b0);
    run_cycle();
    check("byte_wr_rd", rsp0_rdata, 32'h0000AB00);

    // Single read with one-cycle response pulse
    set_req(0, 1'b1, 32'h100, 32'h0, 4'b0000, 1'b0);
    run_cycle();
    check("read_rsp_valid", 32'(rsp0_valid), 32'd1);
    check("read_rsp_data", rsp0_rdata, 32'hDEADBEEF);
    idle_reqs();
    run_cycle();

    // Contention from a fresh reset
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b1, 32'h14, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("contend_grant1", 32'(obs_r1), 32'(i % 2));
`else
      check("contend_grant1", 32'(obs_r1), 32'd0);
`endif
    end

    // Requester 1 locks for three write beats while requester 0 waits
    idle_reqs();
    set_req(1, 1'b1, 32'h200, 32'h11223344, 4'hF, 1'b1);
    run_cycle();
    set_req(0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    run_cycle();
    check("lock_block0_a", 32'(obs_r0), 32'd0);
    set_req(1, 1'b1, 32'h200, 32'h55667788, 4'hF, 1'b0);
    run_cycle();
    check("lock_block0_b", 32'(obs_r0), 32'd0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    run_cycle();
    check("lock_release0", 32'(obs_r0), 32'd1);

    // Forced exit at the beat limit with requester 1 waiting
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h30, 32'h0, 4'h0, 1'b1);
    set_req(1, 1'b1, 32'h34, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < MAXL; i++) begin
      run_cycle();
      check("maxlock_hold0", 32'(obs_r0), 32'd1);
    end
    run_cycle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("maxlock_next1", 32'(obs_r1), 32'd1);
`else
    check("maxlock_next1", 32'(obs_r1), 32'd0);
`endif

    // Reset in the middle of a lock owned by requester 1
    idle_reqs();
    run_cycle();
    set_req(1, 1'b1, 32'h40, 32'h0, 4'h0, 1'b1);
    run_cycle();
    set_req(0, 1'b1, 32'h44, 32'h0, 4'h0, 1'b0);
    rst = 1'b1;
    run_cycle();
    check("rst_lock_rsp1", 32'(rsp1_valid), 32'd0);
    rst = 1'b0;
    run_cycle();
    check("rst_lock_idle0", 32'(obs_r0), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int n = 0; n < 2; n++) begin
        set_req(n, ($urandom_range(0, 3) != 0), $urandom(), $urandom(),
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 1));
      end
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
